// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: line-granular backing memory behind a cache miss/writeback port.
// Whole-line read/write requests are queued in an in-order FIFO, served one at a
// time after a fixed latency, and read responses are held until acknowledged.
// Optional feature macro: LINE_MEM_WRITE_ACK_EN -- when defined, writes also
// produce a response (o_resp_is_write=1) that waits for i_ack.
module line_mem_ctrl #(
    parameter int N_ELEMENTS = 2,
    parameter int N_BYTES    = 4,
    parameter int PA_WIDTH   = 8,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_req_enable,
    output logic                              o_req_ready,
    input  logic                              i_req_type,
    input  logic [PA_WIDTH-1:0]               i_req_addr,
    input  logic [N_ELEMENTS*N_BYTES*8-1:0]   i_req_data,
    output logic                              o_resp_enable,
    output logic [PA_WIDTH-1:0]               o_resp_addr,
    output logic [N_ELEMENTS*N_BYTES*8-1:0]   o_resp_data,
    output logic                              o_resp_is_write,
    input  logic                              i_ack,
    output logic                              o_busy
);

    localparam int LINE_WIDTH  = N_ELEMENTS * N_BYTES * 8;
    localparam int OFFSET_BITS = $clog2(N_ELEMENTS * N_BYTES);
    localparam int INDEX_BITS  = PA_WIDTH - OFFSET_BITS;
    localparam int N_LINES     = 1 << INDEX_BITS;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    typedef struct packed {
        logic                  is_write;
        logic [PA_WIDTH-1:0]   addr;
        logic [LINE_WIDTH-1:0] data;
    } req_t;

    // Request queue storage and bookkeeping
    req_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              push, pop, full;

    // Working request, latency counter and controller state
    state_e            state_q, state_d;
    req_t              work_q, work_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Registered response outputs
    logic                  resp_enable_q, resp_enable_d;
    logic [PA_WIDTH-1:0]   resp_addr_q, resp_addr_d;
    logic [LINE_WIDTH-1:0] resp_data_q, resp_data_d;
`ifdef LINE_MEM_WRITE_ACK_EN
    logic                  resp_is_write_q, resp_is_write_d;
`endif

    // Line array
    logic [LINE_WIDTH-1:0] mem_q [N_LINES];
    logic                  mem_we;
    logic [INDEX_BITS-1:0] mem_idx;
    logic [LINE_WIDTH-1:0] mem_rdata;

    assign full      = (count_q == FULL_COUNT);
    assign mem_idx   = work_q.addr[PA_WIDTH-1:OFFSET_BITS];
    assign mem_rdata = mem_q[mem_idx];

    // Next-state logic for the queue, the controller and the response registers
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d       = state_q;
        work_d        = work_q;
        cnt_d         = cnt_q;
        resp_enable_d = resp_enable_q;
        resp_addr_d   = resp_addr_q;
        resp_data_d   = resp_data_q;
`ifdef LINE_MEM_WRITE_ACK_EN
        resp_is_write_d = resp_is_write_q;
`endif
        mem_we = 1'b0;
        pop    = 1'b0;
        push   = i_req_enable && !full;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    work_d  = fifo_mem[rd_ptr_q];
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!work_q.is_write) begin
                    resp_enable_d = 1'b1;
                    resp_addr_d   = work_q.addr;
                    resp_data_d   = mem_rdata;
`ifdef LINE_MEM_WRITE_ACK_EN
                    resp_is_write_d = 1'b0;
`endif
                    state_d = RESP;
                end else begin
                    mem_we = 1'b1;
`ifdef LINE_MEM_WRITE_ACK_EN
                    resp_enable_d   = 1'b1;
                    resp_addr_d     = work_q.addr;
                    resp_data_d     = work_q.data;
                    resp_is_write_d = 1'b1;
                    state_d         = RESP;
`else
                    state_d = IDLE;
`endif
                end
            end
            RESP: begin
                if (i_ack) begin
                    resp_enable_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q       <= IDLE;
            work_q        <= '0;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            resp_enable_q <= 1'b0;
            resp_addr_q   <= '0;
            resp_data_q   <= '0;
`ifdef LINE_MEM_WRITE_ACK_EN
            resp_is_write_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            work_q        <= work_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            resp_enable_q <= resp_enable_d;
            resp_addr_q   <= resp_addr_d;
            resp_data_q   <= resp_data_d;
`ifdef LINE_MEM_WRITE_ACK_EN
            resp_is_write_q <= resp_is_write_d;
`endif
        end
    end

    // Queue payload: only entries between the pointers are ever read, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{is_write: i_req_type, addr: i_req_addr, data: i_req_data};
        end
    end

    // Line array: committed by a write when its latency expires
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the array must read back as zero after reset, so every line is a resettable flop.
            for (int i = 0; i < N_LINES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_idx] <= work_q.data;
        end
    end

    assign o_req_ready   = !full;
    assign o_resp_enable = resp_enable_q;
    assign o_resp_addr   = resp_addr_q;
    assign o_resp_data   = resp_data_q;
    assign o_busy        = (count_q != '0) || (state_q != IDLE);
`ifdef LINE_MEM_WRITE_ACK_EN
    assign o_resp_is_write = resp_is_write_q;
`else
    assign o_resp_is_write = 1'b0;
`endif

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Testbench for line_mem_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model
// (request queue, a server that finishes LATENCY edges after the pop, line array).
module tb_line_mem_ctrl;

    localparam int DEPTH   = 2;
    localparam int LAT     = 3;
    localparam int PA_W    = 8;
    localparam int LW      = 64;
    localparam int N_LINES = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req_enable = 1'b0;
    logic          o_req_ready;
    logic          i_req_type = 1'b0;
    logic [PA_W-1:0] i_req_addr = '0;
    logic [LW-1:0] i_req_data = '0;
    logic          o_resp_enable;
    logic [PA_W-1:0] o_resp_addr;
    logic [LW-1:0] o_resp_data;
    logic          o_resp_is_write;
    logic          i_ack = 1'b0;
    logic          o_busy;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    line_mem_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .i_req_enable    (i_req_enable),
        .o_req_ready     (o_req_ready),
        .i_req_type      (i_req_type),
        .i_req_addr      (i_req_addr),
        .i_req_data      (i_req_data),
        .o_resp_enable   (o_resp_enable),
        .o_resp_addr     (o_resp_addr),
        .o_resp_data     (o_resp_data),
        .o_resp_is_write (o_resp_is_write),
        .i_ack           (i_ack),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit            wr;
        logic [7:0]    addr;
        logic [63:0]   data;
    } mreq_t;

    mreq_t       mq[$];
    mreq_t       m_cur;
    bit          m_srv;
    longint      m_cycle;
    longint      m_done_at;
    bit          m_resp_valid;
    bit          m_resp_wr;
    logic [7:0]  m_resp_addr;
    logic [63:0] m_resp_data;
    logic [63:0] m_mem [N_LINES];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_srv        = 1'b0;
            m_cycle      = 0;
            m_done_at    = 0;
            m_resp_valid = 1'b0;
            m_resp_wr    = 1'b0;
            m_resp_addr  = '0;
            m_resp_data  = '0;
            for (int i = 0; i < N_LINES; i++) m_mem[i] = '0;
        end else begin
            bit    acc;
            mreq_t nr;
            acc = i_req_enable && (mq.size() < DEPTH);
            nr.wr = i_req_type; nr.addr = i_req_addr; nr.data = i_req_data;
            m_cycle++;
            if (m_resp_valid) begin
                if (i_ack) m_resp_valid = 1'b0;
            end else if (m_srv) begin
                if (m_cycle == m_done_at) begin
                    int idx;
                    idx   = int'(m_cur.addr) / 8;
                    m_srv = 1'b0;
                    if (!m_cur.wr) begin
                        m_resp_valid = 1'b1;
                        m_resp_wr    = 1'b0;
                        m_resp_addr  = m_cur.addr;
                        m_resp_data  = m_mem[idx];
                    end else begin
                        m_mem[idx] = m_cur.data;
`ifdef LINE_MEM_WRITE_ACK_EN
                        m_resp_valid = 1'b1;
                        m_resp_wr    = 1'b1;
                        m_resp_addr  = m_cur.addr;
                        m_resp_data  = m_cur.data;
`endif
                    end
                end
            end else if (mq.size() != 0) begin
                m_cur     = mq.pop_front();
                m_srv     = 1'b1;
                m_done_at = m_cycle + LAT;
            end
            if (acc) mq.push_back(nr);
        end
    end

    // Compare process: outputs against the model on every falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("ready",  o_req_ready, (mq.size() < DEPTH));
            check("busy",   o_busy, (mq.size() != 0) || m_srv || m_resp_valid);
            check("resp_en", o_resp_enable, m_resp_valid);
            if (m_resp_valid) begin
                check("resp_addr", o_resp_addr, m_resp_addr);
                check("resp_data", o_resp_data, m_resp_data);
                check("resp_wr",   o_resp_is_write, m_resp_wr);
            end
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic send(input bit wr, input logic [7:0] addr, input logic [63:0] data);
        int n;
        i_req_enable = 1'b1; i_req_type = wr; i_req_addr = addr; i_req_data = data;
        n = 0;
        while (!o_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", (n >= 100), 1'b0);
        @(negedge clk);
        i_req_enable = 1'b0;
    endtask

    task automatic get_resp(input bit exp_wr, input logic [7:0] exp_addr,
                            input logic [63:0] exp_data, input bit do_ack);
        int n;
        n = 0;
        while (!o_resp_enable && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("resp_timeout", (n >= 100), 1'b0);
        check("lit_addr", o_resp_addr, exp_addr);
        check("lit_data", o_resp_data, exp_data);
        check("lit_is_write", o_resp_is_write, exp_wr);
        if (do_ack) begin
            i_ack = 1'b1;
            @(negedge clk);
            i_ack = 1'b0;
        end
    endtask

    initial begin
        int lat;
        logic [7:0]  hold_addr;
        logic [63:0] hold_data;

        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", o_req_ready, 1'b1);
        check("rst_resp_en", o_resp_enable, 1'b0);
        check("rst_addr", o_resp_addr, 8'h00);
        check("rst_data", o_resp_data, 64'h0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_is_write", o_resp_is_write, 1'b0);
        rst = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);

        // 1: read 0x05 latency and hold-until-ack
        send(1'b0, 8'h05, 64'h0);
        lat = 0;
        while (!o_resp_enable && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("read_latency", lat, 4);
        check("r05_addr", o_resp_addr, 8'h05);
        check("r05_data", o_resp_data, 64'h0);
        hold_addr = o_resp_addr;
        hold_data = o_resp_data;
        repeat (3) begin
            @(negedge clk);
            check("hold_en", o_resp_enable, 1'b1);
            check("hold_addr", o_resp_addr, hold_addr);
            check("hold_data", o_resp_data, hold_data);
        end
        i_ack = 1'b1;
        @(negedge clk);
        i_ack = 1'b0;
        check("ack_drops_en", o_resp_enable, 1'b0);

        // 2: write 0x0F then read 0x08 (same line 1)
        send(1'b1, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
        send(1'b0, 8'h08, 64'h0);
`ifdef LINE_MEM_WRITE_ACK_EN
        get_resp(1'b1, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b1);
`endif
        get_resp(1'b0, 8'h08, 64'hAAAAAAAA_BBBBBBBB, 1'b1);

        // 3: queue fills while a response waits for ack
        send(1'b0, 8'h10, 64'h0);
        get_resp(1'b0, 8'h10, 64'h0, 1'b0);
        send(1'b0, 8'hA0, 64'h0);
        send(1'b0, 8'hA8, 64'h0);
        i_req_enable = 1'b1; i_req_type = 1'b0; i_req_addr = 8'hB0;
        check("full_not_ready", o_req_ready, 1'b0);
        i_ack = 1'b1;
        @(negedge clk);
        i_ack = 1'b0;
        send(1'b0, 8'hB0, 64'h0);
        get_resp(1'b0, 8'hA0, 64'h0, 1'b1);
        get_resp(1'b0, 8'hA8, 64'h0, 1'b1);
        get_resp(1'b0, 8'hB0, 64'h0, 1'b1);

        // 4: write 0xA0, read 0xA4
        send(1'b1, 8'hA0, 64'h22222222_33333333);
        send(1'b0, 8'hA4, 64'h0);
`ifdef LINE_MEM_WRITE_ACK_EN
        get_resp(1'b1, 8'hA0, 64'h22222222_33333333, 1'b1);
`endif
        get_resp(1'b0, 8'hA4, 64'h22222222_33333333, 1'b1);

        // 5: reset while BUSY with two requests queued drops the pending write
        send(1'b1, 8'h40, 64'h12345678_9ABCDEF0);
        send(1'b0, 8'h44, 64'h0);
        send(1'b0, 8'h48, 64'h0);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_en", o_resp_enable, 1'b0);
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_ready", o_req_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(1'b0, 8'h40, 64'h0);
        get_resp(1'b0, 8'h40, 64'h0, 1'b1);
        send(1'b0, 8'h0F, 64'h0);
        get_resp(1'b0, 8'h0F, 64'h0, 1'b1);

        // 6: ack while idle is ignored
        i_ack = 1'b1;
        repeat (2) @(negedge clk);
        i_ack = 1'b0;
        check("idle_ack_en", o_resp_enable, 1'b0);
        check("idle_ack_busy", o_busy, 1'b0);

        // Randomized traffic over a few lines so writes and reads collide
        for (int c = 0; c < 1500; c++) begin
            i_req_enable = ($urandom % 2) == 1;
            i_req_type   = ($urandom % 2) == 1;
            i_req_addr   = 8'($urandom_range(0, 47));
            i_req_data   = {$urandom, $urandom};
            i_ack        = ($urandom % 3) != 0;
            if (c == 700) begin
                #1 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        // Drain
        i_req_enable = 1'b0;
        i_ack = 1'b1;
        repeat (40) @(negedge clk);
        i_ack = 1'b0;
        check("drain_busy", o_busy, 1'b0);
        check("drain_en", o_resp_enable, 1'b0);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_mem_ctrl.md
Name: line_mem_ctrl

Overview:
- Line-granular backing memory and controller sitting directly downstream of the cache miss/writeback port.
- Accepts whole-line read and write requests and returns read lines after a fixed programmable latency.
- Buffers requests in a small in-order FIFO.
- Holds each read response until the cache acknowledges it.

Parameters:
N_ELEMENTS, 2, elements per line
N_BYTES, 4, bytes per element; LINE_WIDTH = N_ELEMENTS*N_BYTES*8
PA_WIDTH, 8, physical address width
LATENCY, 3, cycles from dequeue to completion; legal range is 1 or more
FIFO_DEPTH, 2, request queue entries; power of two, 2 or more

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
i_req_enable  in  1  request valid
o_req_ready  out  1  request queue not full
i_req_type  in  1  0 = read line, 1 = write line
i_req_addr  in  PA_WIDTH  request byte address
i_req_data  in  LINE_WIDTH  write line data; ignored for reads
o_resp_enable  out  1  response valid
o_resp_addr  out  PA_WIDTH  echo of the request address, unmodified
o_resp_data  out  LINE_WIDTH  read line data
o_resp_is_write  out  1  response type; see Optional Feature
i_ack  in  1  cache consumed the response
o_busy  out  1  FIFO not empty, or state is not IDLE

Behaviour:
- Addressing:
  - OFFSET_BITS = $clog2(N_ELEMENTS*N_BYTES).
  - Line index = i_req_addr >> OFFSET_BITS.
  - Array size is 2^(PA_WIDTH-OFFSET_BITS) lines (32 at defaults).
- Reset (rst low, asynchronous):
  - FIFO emptied; state forced to IDLE; counter cleared.
  - Every array line cleared to 0.
  - Outputs: o_resp_enable=0, o_resp_addr=0, o_resp_data=0, o_resp_is_write=0, o_busy=0, o_req_ready=1.
  - Reset asserted mid-operation drops all queued and in-flight requests. A pending write is not committed.
- Enqueue:
  - Request accepted on an edge where i_req_enable && o_req_ready.
  - o_req_ready = !full and is purely registered state; there is no same-cycle bypass.
  - When full, a simultaneous enqueue and dequeue is still refused.
  - FIFO pointers wrap modulo FIFO_DEPTH. A count register distinguishes full from empty.
- FSM:
  - IDLE: if FIFO is non-empty, pop the head into the working registers, load counter=LATENCY-1, go to BUSY.
  - BUSY:
    - While counter != 0, decrement.
    - At counter == 0, a read latches array[index] into o_resp_data, latches the address into o_resp_addr, sets o_resp_enable=1 and goes to RESP.
    - At counter == 0, a write stores i_req_data captured at enqueue into array[index] and goes to IDLE.
  - RESP:
    - Outputs hold stable while o_resp_enable=1 and i_ack=0.
    - On an edge with i_ack=1, o_resp_enable clears and state goes to IDLE.
- Latency:
  - Request accepted at edge E0 with FIFO empty and IDLE: pop at E1, o_resp_enable high after edge E1+LATENCY.
  - The next queued request is popped on the first edge after returning to IDLE.
- Ordering is strict FIFO, so a read after a write to the same line returns the written data.
- i_ack while o_resp_enable=0 is ignored.
- Requests may be enqueued during BUSY or RESP while not full.
- o_resp_data and o_resp_addr keep their last value after the ack; they are only meaningful while o_resp_enable=1.

Optional Feature:
- Macro: LINE_MEM_WRITE_ACK_EN.
- Defined:
  - A write at counter == 0 commits, then enters RESP with o_resp_enable=1, o_resp_is_write=1, o_resp_addr=address, and o_resp_data set to the written line.
  - The write response waits for i_ack like a read response.
  - Read responses drive o_resp_is_write=0.
- Undefined:
  - Writes complete silently and return to IDLE.
  - o_resp_is_write is tied to 0.

Test Plan:
- Reset then read 0x05: accepted at E0 -> o_resp_enable rises after E4 (LATENCY=3), o_resp_addr=05, o_resp_data=0; hold i_ack=0 for 3 cycles -> outputs stable; i_ack=1 -> enable low next cycle.
- Write 0x0F data {AAAAAAAA,BBBBBBBB}, then read 0x08 back-to-back -> read returns {AAAAAAAA,BBBBBBBB}, same line index 1, o_resp_addr=08.
- Three reads back-to-back with i_req_enable held -> first two accepted, o_req_ready=0 on the third until the first is popped; responses arrive in order A0, A8, B0.
- Write 0xA0 {22222222,33333333}, read 0xA4 -> data {22222222,33333333}; with LINE_MEM_WRITE_ACK_EN defined, a write response (o_resp_is_write=1) precedes the read response.
- Assert rst low while in BUSY with 2 queued requests -> o_resp_enable=0, o_busy=0, o_req_ready=1 immediately; later read of that line returns 0 (write dropped).
- i_ack pulsed while idle, and i_req_enable with o_req_ready=0 -> no state change, no spurious response.
